// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler that hands 16-bit words from NCH
// requester channels to a single UART transmitter. It launches each word,
// waits for the transmitter to acknowledge with busy, and inserts a fixed idle
// gap between consecutive words.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no word owned; arbitrate among valid & enabled channels
// LAUNCH    | word latched; strobe tx_ena for one clock
// WAIT_BUSY | waiting for tx_busy to rise, bounded by TMO_CYC clocks
// WAIT_DONE | transmitter shifting the word; wait for tx_busy to fall
// GAP       | mandatory idle spacing of GAP_CYC clocks before next grant
module uart_tx_sched #(
    parameter int NCH     = 4,
    parameter int GAP_CYC = 4,
    parameter int TMO_CYC = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NCH-1:0]    ch_mask,
    input  logic [NCH-1:0]    req_valid,
    input  logic [16*NCH-1:0] req_data,
    output logic [NCH-1:0]    req_ready,
    output logic [15:0]       tx_data,
    output logic              tx_ena,
    input  logic              tx_busy,
    output logic [2:0]        grant_id,
    output logic              sched_busy,
    output logic              tmo_err
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    // The timeout compare fires on the last allowed clock; GAP counts down to
    // zero, and a zero gap still spends one clock in GAP.
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);
    localparam logic [7:0] GAP_LOAD = (GAP_CYC == 0) ? 8'd0 : 8'(GAP_CYC - 1);
    localparam logic [2:0] LAST_RST = 3'(NCH - 1);

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic [2:0]       r_last_grant;
    logic [2:0]       r_grant_id;
    logic [15:0]      r_tx_data;
    logic             r_tx_ena;
    logic             r_tmo_err;
    logic [NCH-1:0]   r_req_ready;

    logic [NCH-1:0]   w_elig;
    logic             w_found;
    logic [2:0]       w_win;
    logic [NCH-1:0]   w_onehot;
    logic [15:0]      w_word;

    assign w_elig = req_valid & ch_mask;

    // Round-robin pick: channels above the last grant first, then wrap to 0.
    always_comb begin
        w_found  = 1'b0;
        w_win    = '0;
        w_onehot = '0;
        w_word   = '0;
        for (int j = 0; j < NCH; j++) begin
            if (!w_found && w_elig[j] && (3'(j) > r_last_grant)) begin
                w_found     = 1'b1;
                w_win       = 3'(j);
                w_onehot[j] = 1'b1;
                w_word      = req_data[16*j +: 16];
            end
        end
        for (int j = 0; j < NCH; j++) begin
            if (!w_found && w_elig[j] && (3'(j) <= r_last_grant)) begin
                w_found     = 1'b1;
                w_win       = 3'(j);
                w_onehot[j] = 1'b1;
                w_word      = req_data[16*j +: 16];
            end
        end
    end

    // Scheduler FSM with registered strobes, latched word and shared counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_last_grant <= LAST_RST;
            r_grant_id   <= '0;
            r_tx_data    <= '0;
            r_tx_ena     <= 1'b0;
            r_tmo_err    <= 1'b0;
            r_req_ready  <= '0;
        end else begin
            r_tx_ena    <= 1'b0;
            r_tmo_err   <= 1'b0;
            r_req_ready <= '0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_req_ready  <= w_onehot;
                        r_tx_data    <= w_word;
                        r_grant_id   <= w_win;
                        r_last_grant <= w_win;
                        r_state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_tx_ena <= 1'b1;
                    r_cnt    <= '0;
                    r_state  <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_state <= WAIT_DONE;
                    end else if (r_cnt == TMO_LAST) begin
                        // Transmitter never took the word; drop it and move on.
                        r_tmo_err <= 1'b1;
                        r_cnt     <= GAP_LOAD;
                        r_state   <= GAP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_cnt   <= GAP_LOAD;
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign tx_data    = r_tx_data;
    assign tx_ena     = r_tx_ena;
    assign grant_id   = r_grant_id;
    assign tmo_err    = r_tmo_err;
    assign sched_busy = (r_state != IDLE);

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter NCH, default 4, SHALL set the number of requester channels (range 2..8).
REQ-002 Parameter GAP_CYC, default 4, SHALL set the idle clocks inserted between consecutive words (0..255).
REQ-003 Parameter TMO_CYC, default 16, SHALL set the clocks allowed for transmitter busy to rise after launch (1..255).
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 ch_mask  input  NCH  per-channel enable; 0 excludes that channel from arbitration.
REQ-007 req_valid  input  NCH  per-channel request; held with data until accepted.
REQ-008 req_data  input  16*NCH  channel i word at bits [16i+15:16i].
REQ-009 req_ready  output  NCH  one-hot, one-clock accept pulse to the granted channel.
REQ-010 tx_data  output  16  word presented to the 16-bit UART transmitter.
REQ-011 tx_ena  output  1  one-clock start strobe to the transmitter.
REQ-012 tx_busy  input  1  transmitter busy flag.
REQ-013 grant_id  output  3  index of the channel currently owning the transmitter.
REQ-014 sched_busy  output  1  high in every state except IDLE.
REQ-015 tmo_err  output  1  one-clock pulse when tx_busy fails to rise within TMO_CYC clocks.

Function
REQ-016 The FSM SHALL have the states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE and GAP.
REQ-017 In IDLE, when (req_valid & ch_mask) is nonzero, the block SHALL select the winner round-robin, searching from (last_grant+1) mod NCH upward with wrap-around.
REQ-018 In that same clock the block SHALL pulse req_ready for the winner, latch its word into tx_data, update grant_id and last_grant, and go to LAUNCH.
REQ-019 In LAUNCH the block SHALL drive tx_ena=1 for exactly one clock, clear the timeout counter, and go to WAIT_BUSY.
REQ-020 tx_data SHALL stay stable from latch until the next grant.
REQ-021 In WAIT_BUSY, tx_busy=1 SHALL move the FSM to WAIT_DONE.
REQ-022 In WAIT_BUSY, if the counter reaches TMO_CYC with tx_busy=0, the block SHALL pulse tmo_err, drop the word, and go to GAP.
REQ-023 In WAIT_DONE, tx_busy=0 SHALL move the FSM to GAP; there is no timeout in this state.
REQ-024 GAP SHALL last exactly GAP_CYC clocks, then return to IDLE; GAP_CYC=0 SHALL return to IDLE after one clock.
REQ-025 Latency from req_valid high in IDLE to tx_ena high SHALL be exactly 1 clock (ready at cycle N, ena at cycle N+1).
REQ-026 A channel whose req_valid drops before req_ready SHALL NOT be granted; requests already granted are unaffected.
REQ-027 Clearing a ch_mask bit SHALL exclude that channel from subsequent arbitration only and SHALL NOT abort a word in progress.
REQ-028 Each channel SHALL wait at most NCH-1 other grants while it is continuously valid and enabled.
REQ-029 Counters SHALL be 8 bits wide, and the round-robin pointer SHALL wrap at NCH-1 to 0.

Reset
REQ-030 During reset the block SHALL force: FSM=IDLE, tx_ena=0, req_ready=0, tx_data=0, grant_id=0, last_grant=NCH-1 (so channel 0 has first priority), sched_busy=0, tmo_err=0, counters=0.
REQ-031 Reset asserted mid-transfer SHALL immediately drop tx_ena and req_ready and discard the latched word without any later replay.
REQ-032 After reset deasserts, the first grant SHALL occur no earlier than the first rising edge with reset low.

Verification
REQ-033 Single request: ch1 valid with 0xA55A, transmitter model busy 3 clocks after ena for 20 clocks -> req_ready=0010 once, tx_ena one clock later with tx_data=0xA55A, sched_busy high until GAP_CYC clocks after busy falls.
REQ-034 Fairness: all 4 channels continuously valid with distinct words -> grant order 0,1,2,3,0, with exactly one tx_ena per word.
REQ-035 Mask: ch_mask=1011 with all valid -> channel 2 is never granted; the order is 0,1,3,0.
REQ-036 Timeout: tx_busy tied 0 -> tmo_err pulses TMO_CYC clocks after tx_ena, and the next grant follows GAP_CYC+1 clocks later.
REQ-037 Reset during WAIT_DONE -> all outputs take reset values asynchronously; after release, with ch2 valid, channel 2 is granted first only if channels 0 and 1 are idle.
REQ-038 Withdrawn request: ch3 valid for 1 clock while the FSM is in WAIT_DONE, then dropped -> no req_ready to ch3 and no tx_ena.
